// File: rtl/pixel_stream_decoder.sv
// Pixel stream decoder: expands CLUT8 / CLUT4 / RL7 coded bytes into one colour
// index per enabled pixel, tracking the column and flagging end of line.
module pixel_stream_decoder #(
  parameter int LINE_WIDTH = 384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [1:0] mode,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_strobe,
  input  logic       pixel_en,
  output logic [7:0] out_index,
  output logic       out_valid,
  output logic       underrun,
  output logic       line_done
);

  typedef enum logic [1:0] {S_DONE, S_FETCH, S_FETCH_LEN, S_HOLD} state_t;

  localparam logic [1:0] MODE_RL7   = 2'd1;
  localparam logic [1:0] MODE_CLUT4 = 2'd2;
  localparam logic [9:0] LAST_COL   = 10'(LINE_WIDTH - 1);

  state_t     state_reg, state_next;
  logic [1:0] mode_reg, mode_next;
  logic [7:0] colour_reg, colour_next;
  logic [7:0] remaining_reg, remaining_next;
  logic       to_eol_reg, to_eol_next;
  logic [3:0] nibble_reg, nibble_next;
  logic [9:0] column_reg, column_next;
  logic [7:0] out_index_reg, out_index_next;
  logic       out_valid_reg, out_valid_next;
  logic       underrun_reg, underrun_next;
  logic       line_done_reg, line_done_next;

  logic ready;
  logic fetching;
  logic active;

  assign ready    = (remaining_reg != 8'd0) || to_eol_reg;
  assign fetching = (state_reg == S_FETCH) || (state_reg == S_FETCH_LEN);
  assign active   = (state_reg != S_DONE);
  // A new line overrides any byte acceptance in the same cycle.
  assign in_strobe = in_valid && fetching && !ready && !line_start;

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    colour_next    = colour_reg;
    remaining_next = remaining_reg;
    to_eol_next    = to_eol_reg;
    nibble_next    = nibble_reg;
    column_next    = column_reg;
    out_index_next = out_index_reg;
    out_valid_next = 1'b0;
    underrun_next  = 1'b0;
    line_done_next = 1'b0;

    if (line_start) begin
      state_next     = S_FETCH;
      mode_next      = mode;
      colour_next    = 8'h00;
      remaining_next = 8'h00;
      to_eol_next    = 1'b0;
      nibble_next    = 4'h0;
      column_next    = 10'd0;
    end else begin
      if (in_strobe) begin
        if (state_reg == S_FETCH_LEN) begin
          if (in_byte != 8'h00) remaining_next = in_byte;
          else                  to_eol_next    = 1'b1;
          state_next = S_HOLD;
        end else begin
          case (mode_reg)
            MODE_RL7: begin
              colour_next = {1'b0, in_byte[6:0]};
              if (in_byte[7]) begin
                state_next = S_FETCH_LEN;
              end else begin
                remaining_next = 8'd1;
                state_next     = S_HOLD;
              end
            end
            MODE_CLUT4: begin
              colour_next    = {4'h0, in_byte[7:4]};
              nibble_next    = in_byte[3:0];
              remaining_next = 8'd2;
              state_next     = S_HOLD;
            end
            default: begin
              colour_next    = in_byte;
              remaining_next = 8'd1;
              state_next     = S_HOLD;
            end
          endcase
        end
      end

      if (pixel_en && active) begin
        out_valid_next = 1'b1;
        column_next    = column_reg + 10'd1;
        if (ready) begin
          out_index_next = colour_reg;
          if (!to_eol_reg) begin
            remaining_next = remaining_reg - 8'd1;
            // Second CLUT4 pixel comes from the held low nibble.
            if (mode_reg == MODE_CLUT4 && remaining_reg == 8'd2)
              colour_next = {4'h0, nibble_reg};
            if (remaining_reg == 8'd1)
              state_next = S_FETCH;
          end
        end else begin
          out_index_next = 8'h00;
          underrun_next  = 1'b1;
        end
        if (column_reg == LAST_COL) begin
          line_done_next = 1'b1;
          state_next     = S_DONE;
          colour_next    = 8'h00;
          remaining_next = 8'h00;
          to_eol_next    = 1'b0;
          nibble_next    = 4'h0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_DONE;
      mode_reg      <= 2'd0;
      colour_reg    <= 8'h00;
      remaining_reg <= 8'h00;
      to_eol_reg    <= 1'b0;
      nibble_reg    <= 4'h0;
      column_reg    <= 10'd0;
      out_index_reg <= 8'h00;
      out_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      line_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      colour_reg    <= colour_next;
      remaining_reg <= remaining_next;
      to_eol_reg    <= to_eol_next;
      nibble_reg    <= nibble_next;
      column_reg    <= column_next;
      out_index_reg <= out_index_next;
      out_valid_reg <= out_valid_next;
      underrun_reg  <= underrun_next;
      line_done_reg <= line_done_next;
    end
  end

  assign out_index = out_index_reg;
  assign out_valid = out_valid_reg;
  assign underrun  = underrun_reg;
  assign line_done = line_done_reg;

endmodule

// File: tb/tb_pixel_stream_decoder.sv
// Scoreboard bench for pixel_stream_decoder with an 8-pixel line: expected
// pixels are queued as pixel_en is driven and compared when out_valid appears.
module tb_pixel_stream_decoder;

  localparam int LW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [1:0] mode;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_strobe;
  logic       pixel_en;
  logic [7:0] out_index;
  logic       out_valid;
  logic       underrun;
  logic       line_done;

  typedef struct {
    logic [7:0] idx;
    logic       ur;
    logic       ld;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[$];
  logic [1:0] cur_mode;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         strobe_cnt;

  always #5 clk = ~clk;

  pixel_stream_decoder #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .mode(mode),
    .in_byte(in_byte), .in_valid(in_valid), .in_strobe(in_strobe),
    .pixel_en(pixel_en), .out_index(out_index), .out_valid(out_valid),
    .underrun(underrun), .line_done(line_done)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle of stimulus; the upstream model offers the head of src_q.
  task automatic step(input logic ls, input logic pen);
    logic stb;
    @(negedge clk);
    #2;
    line_start = ls;
    mode       = cur_mode;
    pixel_en   = pen;
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_byte  = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_byte  = 8'h00;
    end
    #1;
    stb = in_strobe;
    if (ls) check_value("ls_no_strobe", {31'd0, stb}, 32'd0);
    if (stb) strobe_cnt++;
    @(posedge clk);
    #1;
    if (stb) void'(src_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic pix(input logic [7:0] idx, input logic ur, input logic ld);
    exp_t e;
    e.idx = idx; e.ur = ur; e.ld = ld;
    exp_q.push_back(e);
    step(1'b0, 1'b1);
  endtask

  task automatic new_line(input logic [1:0] m);
    cur_mode   = m;
    strobe_cnt = 0;
    step(1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pixel idx=%02h ur=%0b ld=%0b (want %02h %0b %0b)",
                 out_index, underrun, line_done, e.idx, e.ur, e.ld);
        check_value("out_index", {24'd0, out_index}, {24'd0, e.idx});
        check_value("underrun", {31'd0, underrun}, {31'd0, e.ur});
        check_value("line_done", {31'd0, line_done}, {31'd0, e.ld});
      end
    end
  end

  initial begin
    reset = 1'b1; line_start = 1'b0; mode = 2'd0; in_byte = 8'h00;
    in_valid = 1'b0; pixel_en = 1'b0; cur_mode = 2'd0; strobe_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_out_index", {24'd0, out_index}, 32'd0);
    check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_value("rst_underrun", {31'd0, underrun}, 32'd0);
    check_value("rst_line_done", {31'd0, line_done}, 32'd0);
    src_q.push_back(8'h99);
    in_valid = 1'b1;
    #1;
    check_value("rst_in_strobe", {31'd0, in_strobe}, 32'd0);
    src_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // CLUT8, pixel every 4 clocks
    src_q = '{8'h12, 8'h34};
    new_line(2'd0);
    idle(3); pix(8'h12, 1'b0, 1'b0);
    idle(3); pix(8'h34, 1'b0, 1'b0);
    idle(4);
    check_value("clut8_strobes", strobe_cnt, 2);

    // RL7 literal then run of 4
    src_q = '{8'h05, 8'h83, 8'h04};
    new_line(2'd1);
    idle(3); pix(8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(3); pix(8'h03, 1'b0, 1'b0);
    end
    idle(4);
    check_value("rl7_strobes", strobe_cnt, 3);

    // RL7 run to end of line; nothing consumed after line_done
    src_q = '{8'h81, 8'h00, 8'h55};
    new_line(2'd1);
    idle(2);
    for (int i = 0; i < LW; i++) pix(8'h01, 1'b0, i == LW - 1);
    step(1'b0, 1'b1);
    check_value("done_pen_ignored", {31'd0, out_valid}, 32'd0);
    idle(5);
    check_value("eol_strobes", strobe_cnt, 2);
    check_value("eol_byte_kept", src_q.size(), 1);

    // CLUT4 nibble split
    src_q = '{8'hAB};
    new_line(2'd2);
    idle(2); pix(8'h0A, 1'b0, 1'b0); pix(8'h0B, 1'b0, 1'b0);
    idle(3);
    check_value("clut4_strobes", strobe_cnt, 1);

    // RL7 run longer than the line: remainder discarded
    src_q = '{8'h82, 8'h0A, 8'h66};
    new_line(2'd1);
    idle(2);
    for (int i = 0; i < LW; i++) pix(8'h02, 1'b0, i == LW - 1);
    idle(3);
    check_value("trunc_strobes", strobe_cnt, 2);

    // No upstream data: every pixel is an underrun, column still advances
    src_q.delete();
    new_line(2'd0);
    for (int i = 0; i < LW; i++) pix(8'h00, 1'b1, i == LW - 1);
    idle(3);
    check_value("underrun_strobes", strobe_cnt, 0);

    // line_start mid-run with coincident pixel_en
    src_q = '{8'h85, 8'h20};
    new_line(2'd1);
    idle(2);
    for (int i = 0; i < 3; i++) pix(8'h05, 1'b0, 1'b0);
    src_q.push_back(8'h07);
    strobe_cnt = 0;
    step(1'b1, 1'b1);
    check_value("ls_pen_no_output", {31'd0, out_valid}, 32'd0);
    idle(1);
    pix(8'h07, 1'b0, 1'b0);
    for (int i = 1; i < LW; i++) pix(8'h00, 1'b1, i == LW - 1);
    idle(3);
    check_value("restart_strobes", strobe_cnt, 1);

    // Back-to-back line_start, then acceptance coincident with pixel_en
    src_q = '{8'h44};
    new_line(2'd0);
    step(1'b1, 1'b0);
    pix(8'h00, 1'b1, 1'b0);
    pix(8'h44, 1'b0, 1'b0);
    idle(3);
    check_value("coincident_strobes", strobe_cnt, 1);

    check_value("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_decoder.md
# pixel_stream_decoder

Consumes the byte stream produced by the display file decoder, expands it into one 8-bit colour index per pixel clock enable according to the plane coding mode (CLUT8, CLUT4, RL7), and feeds the CLUT/mixer stage. It owns the upstream `pixel`/`pixel_write`/`pixel_strobe` handshake as consumer, tracks the horizontal column, and signals end of line.

## Interface
- `LINE_WIDTH`, 384: active pixels per line; range 1..1023.
- `clk`  in  1  system clock.
- `reset`  in  1  reset.
- `line_start`  in  1  one-cycle pulse: begin a new line, sample `mode`.
- `mode`  in  2  coding: 0 = CLUT8, 1 = RL7, 2 = CLUT4, 3 = treated as CLUT8.
- `in_byte`  in  8  upstream byte (`pixel`).
- `in_valid`  in  1  upstream byte valid (`pixel_write`).
- `in_strobe`  out  1  byte accepted this cycle (`pixel_strobe`).
- `pixel_en`  in  1  pixel clock enable; one output pixel per enabled cycle during the active line.
- `out_index`  out  8  colour index.
- `out_valid`  out  1  `out_index` updated this cycle.
- `underrun`  out  1  pulse: pixel emitted with no decoded data available.
- `line_done`  out  1  pulse: last pixel of the line emitted.

One clock; reset is synchronous and active-high (`clk`, `reset`).

## Operation
- Decode registers: `colour[7:0]`, `remaining[7:0]`, `to_eol`, `nibble_hold[3:0]`. "Ready" = `remaining != 0 || to_eol`.
- States: DONE (reset state; wait for `line_start`), FETCH (need a byte), FETCH_LEN (RL7 run length pending), HOLD (decode registers ready, no fetch).
- `in_strobe = in_valid && (state == FETCH || state == FETCH_LEN) && !ready`; combinational; a byte is consumed on each edge where `in_strobe` is high.
- FETCH, CLUT8: `colour <= b`, `remaining <= 1` -> HOLD.
- FETCH, CLUT4: `colour <= {4'h0, b[7:4]}`, `nibble_hold <= b[3:0]`, `remaining <= 2` -> HOLD; the second pixel uses `{4'h0, nibble_hold}`.
- FETCH, RL7: `b[7] == 0`: `colour <= {1'b0, b[6:0]}`, `remaining <= 1` -> HOLD. `b[7] == 1`: `colour <= {1'b0, b[6:0]}` -> FETCH_LEN.
- FETCH_LEN: byte `n`; `n != 0` -> `remaining <= n`; `n == 0` -> `to_eol <= 1` (run to end of line) -> HOLD.
- On `pixel_en` in FETCH/FETCH_LEN/HOLD:
  - If ready: emit `colour`, decrement `remaining` (not when `to_eol`).
  - Otherwise: emit 0x00 and pulse `underrun`.
  - The column always advances.
- HOLD -> FETCH when `remaining` reaches 0 and `to_eol == 0`.
- Column counter: 10 bits, cleared on `line_start`. When the pixel at column `LINE_WIDTH-1` is emitted:
  - pulse `line_done`, go to DONE, clear decode registers;
  - any unfinished run or pending nibble is discarded;
  - no byte is consumed in DONE.
- `line_start` in any state: column <= 0, decode registers cleared, `mode` latched, -> FETCH. `line_start` has priority over `pixel_en` and over byte acceptance in the same cycle (`in_strobe` forced 0; no pixel emitted).
- `pixel_en` in DONE: ignored, no output.
- `reset`: state DONE; all registers and outputs 0.

## Timing
- Reset values: `in_strobe` 0 (DONE), `out_index` 0x00, `out_valid` 0, `underrun` 0, `line_done` 0.
- `out_index`, `out_valid`, `underrun`, `line_done` are registered. They are valid in the cycle after the `pixel_en` cycle that produced them; each pulses for one cycle.
- A byte accepted on edge k is usable by a `pixel_en` cycle starting at k+1 or later. Acceptance and `pixel_en` in the same cycle while not ready gives an underrun pixel (0x00), then the loaded data.
- RL7 run setup consumes 2 bytes in at least 2 cycles. Upstream presents its next byte the cycle after a strobe, so back-to-back acceptance is allowed.
- `line_done` is asserted together with the `out_valid` of the last pixel.

## Test plan
- CLUT8, bytes 0x12, 0x34, `pixel_en` every 4 clocks -> `out_index` 0x12, 0x34, no underrun, exactly 2 strobes.
- RL7, bytes 0x05, 0x83, 0x04 -> pixels 0x05, 0x03, 0x03, 0x03, 0x03; 3 strobes.
- RL7, `LINE_WIDTH` = 8, bytes 0x81, 0x00 -> 8 pixels of 0x01, `line_done` with the 8th, `in_strobe` never high again until `line_start`.
- CLUT4, byte 0xAB -> 0x0A then 0x0B. RL7 0x82, 0x0A with `LINE_WIDTH` = 8 -> 8 pixels of 0x02, remainder discarded.
- `in_valid` held 0, `pixel_en` pulsed -> `out_index` 0x00, `out_valid` 1, `underrun` 1 each time; column advances.
- `line_start` mid-run (RL7 0x85, 0x20, after 3 pixels) -> run discarded, column 0, next byte decoded fresh; coincident `pixel_en` produces no output.
